// File: rtl/word_clk_detect.sv
// Word clock receiver: synchronises word_clk_in, measures its period in mclkin cycles and qualifies lock.
// Optional high-time (duty) qualification when WCLK_DUTY_CHECK_EN is defined.
module word_clk_detect #(
    parameter int unsigned DIVCLK     = 256,
    parameter int unsigned TOL        = 2,
    parameter int unsigned LOCK_COUNT = 4,
    localparam int unsigned CW        = $clog2(DIVCLK) + 2
) (
    input  logic          mclkin,
    input  logic          reset,
    input  logic          word_clk_in,
    output logic          rise_strobe,
    output logic [CW-1:0] period,
    output logic          locked,
    output logic          period_err,
    output logic [7:0]    err_count,
    output logic          wclk_lost,
    output logic          duty_err
);

    localparam logic [CW-1:0] MAX = CW'(2 * DIVCLK);
    localparam logic [CW-1:0] LO  = CW'(DIVCLK - TOL);
    localparam logic [CW-1:0] HI  = CW'(DIVCLK + TOL);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    state_t        state, state_d;
    logic          s1, s2, s3;
    logic          rise_c;
    logic [CW-1:0] cnt;
    logic [CW-1:0] meas_c;
    logic          good_c;
    logic          timeout_c;
    logic          duty_bad_c;
    logic [3:0]    match_cnt, match_d;
    logic [CW-1:0] period_d;
    logic          locked_d, perr_d, derr_d, lost_d;

    assign rise_c    = s2 & ~s3;
    assign meas_c    = cnt + CW'(1);
    assign good_c    = (meas_c >= LO) && (meas_c <= HI);
    // A rise on the saturating cycle wins over the timeout.
    assign timeout_c = !rise_c && (cnt == MAX - CW'(1)) && (state != IDLE);

    // Synchroniser, edge flop and period counter
    always_ff @(posedge mclkin) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s3  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= word_clk_in;
            s2 <= s1;
            s3 <= s2;
            if (rise_c)
                cnt <= '0;
            else if (cnt != MAX)
                cnt <= cnt + CW'(1);
        end
    end

`ifdef WCLK_DUTY_CHECK_EN
    localparam logic [CW-1:0] HLO = CW'(DIVCLK / 2 - TOL);
    localparam logic [CW-1:0] HHI = CW'(DIVCLK / 2 + TOL);

    logic          fall_c;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] hmeas_c;

    assign fall_c     = ~s2 & s3;
    assign hmeas_c    = hcnt + CW'(1);
    assign duty_bad_c = fall_c && ((hmeas_c < HLO) || (hmeas_c > HHI));

    // High-time counter, restarted on every rise
    always_ff @(posedge mclkin) begin
        if (reset) begin
            hcnt     <= '0;
            duty_err <= 1'b0;
        end else begin
            duty_err <= derr_d;
            if (rise_c)
                hcnt <= '0;
            else if (hcnt != MAX)
                hcnt <= hcnt + CW'(1);
        end
    end
`else
    assign duty_bad_c = 1'b0;
    assign duty_err   = 1'b0;
`endif

    // Qualification FSM: next state and next output values
    always_comb begin
        state_d  = state;
        match_d  = match_cnt;
        period_d = period;
        locked_d = locked;
        perr_d   = 1'b0;
        derr_d   = 1'b0;
        lost_d   = wclk_lost;
        if (rise_c)
            lost_d = 1'b0;
        case (state)
            IDLE: begin
                if (rise_c)
                    state_d = MEASURE;
            end
            MEASURE: begin
                if (rise_c) begin
                    period_d = meas_c;
                    if (good_c) begin
                        match_d = match_cnt + 4'd1;
                        if (match_cnt == 4'(LOCK_COUNT - 1)) begin
                            locked_d = 1'b1;
                            state_d  = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                        perr_d  = 1'b1;
                    end
                end else if (timeout_c) begin
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                    match_d  = '0;
                    state_d  = IDLE;
                end else if (duty_bad_c) begin
                    derr_d  = 1'b1;
                    match_d = '0;
                end
            end
            LOCKED: begin
                if (rise_c) begin
                    period_d = meas_c;
                    if (!good_c) begin
                        perr_d   = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                        state_d  = MEASURE;
                    end
                end else if (timeout_c) begin
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                    match_d  = '0;
                    state_d  = IDLE;
                end else if (duty_bad_c) begin
                    derr_d   = 1'b1;
                    locked_d = 1'b0;
                    match_d  = '0;
                    state_d  = MEASURE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; simultaneous errors count once
    always_ff @(posedge mclkin) begin
        if (reset) begin
            state       <= IDLE;
            match_cnt   <= '0;
            rise_strobe <= 1'b0;
            period      <= '0;
            locked      <= 1'b0;
            period_err  <= 1'b0;
            err_count   <= '0;
            wclk_lost   <= 1'b0;
        end else begin
            state       <= state_d;
            match_cnt   <= match_d;
            rise_strobe <= rise_c;
            period      <= period_d;
            locked      <= locked_d;
            period_err  <= perr_d;
            wclk_lost   <= lost_d;
            if ((perr_d || derr_d) && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_word_clk_detect.sv
// Directed bench for word_clk_detect (DIVCLK=256, TOL=2, LOCK_COUNT=4).
module tb_word_clk_detect;

    localparam int unsigned CW = 10;

    logic          mclkin = 1'b0;
    logic          reset;
    logic          word_clk_in;
    logic          rise_strobe;
    logic [CW-1:0] period;
    logic          locked;
    logic          period_err;
    logic [7:0]    err_count;
    logic          wclk_lost;
    logic          duty_err;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc        = 0;
    int n_rise     = 0;
    int n_perr     = 0;
    int n_derr     = 0;
    int strobe_cyc = 0;

    int base_rise, base_perr, base_derr;

    word_clk_detect #(.DIVCLK(256), .TOL(2), .LOCK_COUNT(4)) dut (
        .mclkin      (mclkin),
        .reset       (reset),
        .word_clk_in (word_clk_in),
        .rise_strobe (rise_strobe),
        .period      (period),
        .locked      (locked),
        .period_err  (period_err),
        .err_count   (err_count),
        .wclk_lost   (wclk_lost),
        .duty_err    (duty_err)
    );

    always #5 mclkin = ~mclkin;

    always @(posedge mclkin) cyc <= cyc + 1;

    // Event monitor sampled away from the active edge
    always @(negedge mclkin) begin
        if (rise_strobe) begin
            n_rise     <= n_rise + 1;
            strobe_cyc <= cyc;
        end
        if (period_err) n_perr <= n_perr + 1;
        if (duty_err)   n_derr <= n_derr + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One word clock period: hi cycles high, lo cycles low, edges on negedge
    task automatic wclk_cycle(input int hi, input int lo);
        @(negedge mclkin) word_clk_in = 1'b1;
        repeat (hi) @(negedge mclkin);
        word_clk_in = 1'b0;
        repeat (lo - 1) @(negedge mclkin);
    endtask

    task automatic snap();
        base_rise = n_rise;
        base_perr = n_perr;
        base_derr = n_derr;
    endtask

    initial begin
        reset       = 1'b1;
        word_clk_in = 1'b0;
        repeat (3) @(negedge mclkin);
        check("rst_strobe", int'(rise_strobe), 0);
        check("rst_period", int'(period), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_perr", int'(period_err), 0);
        check("rst_errcnt", int'(err_count), 0);
        check("rst_lost", int'(wclk_lost), 0);
        check("rst_derr", int'(duty_err), 0);
        reset = 1'b0;

        // Initial lock with clean 256-cycle periods
        snap();
        wclk_cycle(128, 128);
        check("ref_rise_cnt", n_rise - base_rise, 1);
        check("ref_period", int'(period), 0);
        wclk_cycle(128, 128);
        check("p2_period", int'(period), 256);
        check("p2_locked", int'(locked), 0);
        wclk_cycle(128, 128);
        wclk_cycle(128, 128);
        check("p4_locked", int'(locked), 0);
        wclk_cycle(128, 128);
        check("p5_locked_at_strobe", int'(locked), 1);
        check("p5_period", int'(period), 256);
        check("p5_rise_cnt", n_rise - base_rise, 5);
        check("lock_no_perr", n_perr - base_perr, 0);
        check("lock_errcnt", int'(err_count), 0);

        // One 260-cycle period breaks lock, four good ones restore it
        snap();
        wclk_cycle(130, 130);
        wclk_cycle(128, 128);
        check("bad_period", int'(period), 260);
        check("bad_perr_pulse", n_perr - base_perr, 1);
        check("bad_errcnt", int'(err_count), 1);
        check("bad_unlock", int'(locked), 0);
        wclk_cycle(128, 128);
        wclk_cycle(128, 128);
        wclk_cycle(128, 128);
        check("relock_3good", int'(locked), 0);
        wclk_cycle(128, 128);
        check("relock_4good", int'(locked), 1);

        // Edge-of-tolerance periods 254 and 258
        snap();
        wclk_cycle(127, 127);
        wclk_cycle(129, 129);
        check("tol_254_period", int'(period), 254);
        check("tol_254_locked", int'(locked), 1);
        wclk_cycle(128, 128);
        check("tol_258_period", int'(period), 258);
        check("tol_258_locked", int'(locked), 1);
        check("tol_no_perr", n_perr - base_perr, 0);
        check("tol_errcnt", int'(err_count), 1);

        // Word clock stops: timeout 512 cycles after the last strobe
        snap();
        for (int i = 0; i < 700 && !wclk_lost; i++) @(negedge mclkin);
        check("lost_set", int'(wclk_lost), 1);
        check("lost_delay", cyc - strobe_cyc, 512);
        check("lost_unlock", int'(locked), 0);
        check("lost_period_kept", int'(period), 258);
        check("lost_no_perr", n_perr - base_perr, 0);
        wclk_cycle(128, 128);
        check("lost_cleared", int'(wclk_lost), 0);
        check("lost_ref_period", int'(period), 258);
        check("lost_ref_rise", n_rise - base_rise, 1);
        wclk_cycle(128, 128);
        wclk_cycle(128, 128);
        wclk_cycle(128, 128);
        check("lost_relock_3", int'(locked), 0);
        wclk_cycle(128, 128);
        check("lost_relock_4", int'(locked), 1);

        // One-cycle reset in the low phase while locked
        @(negedge mclkin) word_clk_in = 1'b1;
        repeat (128) @(negedge mclkin);
        word_clk_in = 1'b0;
        repeat (20) @(negedge mclkin);
        reset = 1'b1;
        @(negedge mclkin);
        reset = 1'b0;
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_period", int'(period), 0);
        check("mid_rst_errcnt", int'(err_count), 0);
        check("mid_rst_strobe", int'(rise_strobe), 0);
        repeat (107) @(negedge mclkin);
        wclk_cycle(128, 128);
        check("post_rst_ref_period", int'(period), 0);
        wclk_cycle(128, 128);
        check("post_rst_period", int'(period), 256);
        wclk_cycle(128, 128);
        wclk_cycle(128, 128);
        check("post_rst_lock_4", int'(locked), 0);
        wclk_cycle(128, 128);
        check("post_rst_lock_5", int'(locked), 1);

        // High time of 140 within a 256 period while locked
        snap();
        wclk_cycle(140, 116);
`ifdef WCLK_DUTY_CHECK_EN
        check("duty_pulse", n_derr - base_derr, 1);
        check("duty_unlock", int'(locked), 0);
        check("duty_errcnt", int'(err_count), 1);
`else
        check("duty_pulse", n_derr - base_derr, 0);
        check("duty_locked", int'(locked), 1);
        check("duty_errcnt", int'(err_count), 0);
`endif
        wclk_cycle(128, 128);
        check("duty_next_period", int'(period), 256);
        check("duty_no_perr", n_perr - base_perr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
